// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and helpers for key_debounce_multi (optional KEY_DEBOUNCE_REPEAT_EN)
package key_pkg;

  // Number of flops in each channel's input synchroniser.
  localparam int SYNC_STAGES = 2;

  // Pin level when the key is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// rtl/key_debounce_multi_if.sv - key pins and conditioned key outputs (optional KEY_DEBOUNCE_REPEAT_EN)
interface key_debounce_multi_if #(
  parameter int KEY_NUM = 3
);
  logic [KEY_NUM-1:0] key;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  // Board / control side: drives pins, consumes conditioned state.
  modport master (
    output key,
    input  key_level, key_press, key_release, key_long
  );

  // Conditioner side.
  modport slave (
    input  key,
    output key_level, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce, long press, optional repeat (KEY_DEBOUNCE_REPEAT_EN)
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DW = cnt_width(DEB_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LONG_PRE = HW'(LONG_CYCLES - 2);
  localparam logic REL_LVL = released_level(ACTIVE_LOW != 0);

  // Reject configurations the counters cannot represent.
  if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("key_debounce_ch: invalid cycle parameters");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          dc_q, dc_d;
  logic [HW-1:0]          hc_q, hc_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   p;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rc_q, rc_d;
`endif

  // Next-state logic: shift synchroniser, debounce, hold timer and pulses.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], key_in};
    p         = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
    level_d   = level_q;
    dc_d      = '0;
    if (p != level_q) begin
      if (dc_q == DEB_MAX) begin
        level_d = p;
      end else begin
        dc_d = dc_q + 1'b1;
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;

    // Hold timer saturates at LONG_MAX so key_long fires once per press.
    hc_d   = '0;
    long_d = 1'b0;
    if (level_q) begin
      hc_d   = (hc_q == LONG_MAX) ? hc_q : hc_q + 1'b1;
      long_d = (hc_q == LONG_PRE);
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    // Auto-repeat runs only once the hold timer has saturated.
    rc_d = '0;
    if (level_q && hc_q == LONG_MAX) begin
      if (rc_q == REP_MAX) begin
        press_d = 1'b1;
      end else begin
        rc_d = rc_q + 1'b1;
      end
    end
`endif
  end

  // State registers; reset loads the released pin level into the synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{REL_LVL}};
      dc_q      <= '0;
      hc_q      <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rc_q      <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      dc_q      <= dc_d;
      hc_q      <= hc_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rc_q      <= rc_d;
`endif
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - KEY_NUM independent key conditioners (optional KEY_DEBOUNCE_REPEAT_EN)
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int KEY_NUM       = 3,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  key_debounce_multi_if.slave  bus
);

  logic [KEY_NUM-1:0] level_w;
  logic [KEY_NUM-1:0] press_w;
  logic [KEY_NUM-1:0] release_w;
  logic [KEY_NUM-1:0] long_w;

  // One fully independent channel per key pin.
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_in     (bus.key[i]),
      .key_level  (level_w[i]),
      .key_press  (press_w[i]),
      .key_release(release_w[i]),
      .key_long   (long_w[i])
    );
  end

  assign bus.key_level   = level_w;
  assign bus.key_press   = press_w;
  assign bus.key_release = release_w;
  assign bus.key_long    = long_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - scoreboard bench for key_debounce_multi (honours KEY_DEBOUNCE_REPEAT_EN)
module tb_key_debounce_multi;
  localparam int KN   = 3;
  localparam int DEB  = 10;
  localparam int LONG = 50;
  localparam int REP  = 20;
  localparam int LAT  = 2 + DEB;       // pin edge to key_level change
  localparam int LLAT = LAT + LONG - 1; // pin edge to key_long

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_debounce_multi_if #(.KEY_NUM(KN)) bus ();

  key_debounce_multi #(
    .KEY_NUM      (KN),
    .DEB_CYCLES   (DEB),
    .LONG_CYCLES  (LONG),
    .ACTIVE_LOW   (1),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    logic [KN-1:0] mask;
    int            at;
  } evt_t;
  evt_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push_evt(input int kind, input logic [KN-1:0] m, input int at);
    evt_t e;
    e.kind = kind;
    e.mask = m;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic on_evt(input int kind, input logic [KN-1:0] m);
    evt_t e;
    if (sb.size() == 0) begin
      check($sformatf("spurious_kind%0d", kind), int'(m), 0);
    end else begin
      e = sb.pop_front();
      check("evt_kind", kind, e.kind);
      check("evt_mask", int'(m), int'(e.mask));
      check("evt_cycle", cyc, e.at);
    end
  endtask

  // Any pulse on an output is matched against the next expected event.
  always @(negedge clk) begin
    if (bus.key_press   != '0) on_evt(K_PRESS, bus.key_press);
    if (bus.key_release != '0) on_evt(K_REL,   bus.key_release);
    if (bus.key_long    != '0) on_evt(K_LONG,  bus.key_long);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t;

  initial begin
    bus.key = '1;
    rst     = 1'b1;
    wait_cyc(3);
    check("rst_level",   int'(bus.key_level),   0);
    check("rst_press",   int'(bus.key_press),   0);
    check("rst_release", int'(bus.key_release), 0);
    check("rst_long",    int'(bus.key_long),    0);
    rst = 1'b0;
    wait_cyc(5);

    // Clean press on key 0: level rises exactly LAT cycles later.
    bus.key[0] = 1'b0;
    t = cyc;
    push_evt(K_PRESS, 3'b001, t + LAT);
    wait_cyc(LAT - 1);
    check("t1_level_early", int'(bus.key_level), 0);
    wait_cyc(1);
    check("t1_level", int'(bus.key_level), 1);
    wait_cyc(8);
    bus.key[0] = 1'b1;
    push_evt(K_REL, 3'b001, cyc + LAT);
    wait_cyc(20);
    check("t1_level_rel", int'(bus.key_level), 0);

    // Bouncing key 1, then one deviation of DEB-1 cycles: never accepted.
    for (int i = 0; i < 4; i++) begin
      bus.key[1] = 1'b0;
      wait_cyc(5);
      bus.key[1] = 1'b1;
      wait_cyc(3);
    end
    wait_cyc(20);
    bus.key[1] = 1'b0;
    wait_cyc(DEB - 1);
    bus.key[1] = 1'b1;
    wait_cyc(20);
    check("t2_level", int'(bus.key_level), 0);

    // Long hold on key 2: one key_long, then release.
    bus.key[2] = 1'b0;
    t = cyc;
    push_evt(K_PRESS, 3'b100, t + LAT);
    push_evt(K_LONG,  3'b100, t + LLAT);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    push_evt(K_PRESS, 3'b100, t + LLAT + REP);
`endif
    wait_cyc(80);
    check("t3_level_held", int'(bus.key_level), 3'b100);
    bus.key[2] = 1'b1;
    push_evt(K_REL, 3'b100, cyc + LAT);
    wait_cyc(80);

    // All keys together.
    bus.key = 3'b000;
    push_evt(K_PRESS, 3'b111, cyc + LAT);
    wait_cyc(20);
    check("t4_level", int'(bus.key_level), 3'b111);
    bus.key = 3'b111;
    push_evt(K_REL, 3'b111, cyc + LAT);
    wait_cyc(20);
    check("t4_level_rel", int'(bus.key_level), 0);

    // Reset while key 0 is held: silent, then a fresh press.
    bus.key[0] = 1'b0;
    push_evt(K_PRESS, 3'b001, cyc + LAT);
    wait_cyc(30);
    rst = 1'b1;
    #1;
    check("t5_rst_level", int'(bus.key_level), 0);
    check("t5_rst_press", int'(bus.key_press), 0);
    wait_cyc(3);
    check("t5_rst_level2", int'(bus.key_level), 0);
    rst = 1'b0;
    t = cyc;
    push_evt(K_PRESS, 3'b001, t + LAT);
    wait_cyc(LAT);
    check("t5_level", int'(bus.key_level), 3'b001);
    bus.key[0] = 1'b1;
    push_evt(K_REL, 3'b001, cyc + LAT);
    wait_cyc(20);

    // Very long hold on key 0; level stays high until 132, so repeat at 121 too.
    bus.key[0] = 1'b0;
    t = cyc;
    push_evt(K_PRESS, 3'b001, t + LAT);
    push_evt(K_LONG,  3'b001, t + LLAT);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    push_evt(K_PRESS, 3'b001, t + LLAT + REP);
    push_evt(K_PRESS, 3'b001, t + LLAT + 2 * REP);
    push_evt(K_PRESS, 3'b001, t + LLAT + 3 * REP);
`endif
    wait_cyc(120);
    bus.key[0] = 1'b1;
    push_evt(K_REL, 3'b001, cyc + LAT);
    wait_cyc(30);
    check("t6_level_rel", int'(bus.key_level), 0);

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
